// File: rtl/dtpu_infifo_adapter_pkg.sv
// Shared definitions for the dtpu input FIFO adapter.
// Stats counter widths exist only when DTPU_INFIFO_STATS_EN is defined.
package dtpu_infifo_adapter_pkg;

    localparam int DW_DEFAULT    = 64;
    localparam int DEPTH_DEFAULT = 16;

`ifdef DTPU_INFIFO_STATS_EN
    localparam int STAT_WORDS_W  = 32;
    localparam int STAT_FRAMES_W = 16;
    localparam int STAT_FULL_W   = 32;
`endif

    // Per-cycle FIFO operation, {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/dtpu_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read.
// A read that hits the address being written returns the new word.
module dtpu_sdp_ram #(
    parameter int W     = 65,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read with write-first forwarding for the empty/refill case.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/dtpu_infifo_adapter.sv
// AXI4-Stream slave to FWFT FIFO read port feeding dtpu_core.
// Optional counters: define DTPU_INFIFO_STATS_EN.
module dtpu_infifo_adapter
    import dtpu_infifo_adapter_pkg::*;
#(
    parameter int DATA_WIDTH_FIFO_IN = DW_DEFAULT,
    parameter int DEPTH              = DEPTH_DEFAULT,
    localparam int LVL_W             = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [DATA_WIDTH_FIFO_IN-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [DATA_WIDTH_FIFO_IN-1:0] infifo_dout,
    output logic                          infifo_is_empty,
    input  logic                          infifo_read,
    output logic                          infifo_last,
    output logic [LVL_W-1:0]              infifo_level,
    output logic                          underflow
`ifdef DTPU_INFIFO_STATS_EN
    ,
    output logic [STAT_WORDS_W-1:0]       stat_words,
    output logic [STAT_FRAMES_W-1:0]      stat_frames,
    output logic [STAT_FULL_W-1:0]        stat_full_cyc
`endif
);

    localparam int DW    = DATA_WIDTH_FIFO_IN;
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_addr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_nxt;
    logic             empty_q;
    logic             underflow_q;
    logic             full;
    logic             push;
    logic             pop;
    logic             load;
    logic [DW:0]      head;
    op_e              op;

    assign full          = (level == LVL_W'(DEPTH));
    assign s_axis_tready = !full && !flush && !reset;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = infifo_read && !empty_q && !flush;
    assign op            = op_e'({push, pop});

    // Head register reloads on first word into an empty FIFO or on a pop
    // that leaves something behind; otherwise it holds its value.
    assign load    = !flush && ((empty_q && push) ||
                     (pop && (level != LVL_W'(1) || push)));
    assign rd_addr = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    dtpu_sdp_ram #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({s_axis_tlast, s_axis_tdata}),
        .re    (load),
        .raddr (rd_addr),
        .rdata (head)
    );

    // Next occupancy from this cycle's push/pop combination.
    always_comb begin
        level_nxt = level;
        unique case (op)
            OP_PUSH: level_nxt = level + LVL_W'(1);
            OP_POP:  level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    // Pointers, occupancy and flags; flush drops everything but underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            if (infifo_read && empty_q) underflow_q <= 1'b1;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                empty_q <= 1'b1;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                level   <= level_nxt;
                empty_q <= (level_nxt == '0);
            end
        end
    end

    assign infifo_dout     = head[DW-1:0];
    assign infifo_last     = head[DW];
    assign infifo_is_empty = empty_q;
    assign infifo_level    = level;
    assign underflow       = underflow_q;

`ifdef DTPU_INFIFO_STATS_EN
    // Traffic counters, all wrapping, cleared by reset and flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            stat_words    <= '0;
            stat_frames   <= '0;
            stat_full_cyc <= '0;
        end else begin
            if (push)
                stat_words <= stat_words + STAT_WORDS_W'(1);
            if (push && s_axis_tlast)
                stat_frames <= stat_frames + STAT_FRAMES_W'(1);
            if (s_axis_tvalid && full)
                stat_full_cyc <= stat_full_cyc + STAT_FULL_W'(1);
        end
    end
`endif

endmodule
